afifo_wr_packer: RTL
====================

// Module: afifo_wr_packer
// PURPOSE
//  Write-side front end of the asynchronous FIFO, in the wclk domain.
//  - Accepts a narrow valid/ready input stream and packs RATIO beats into one DSIZE-bit word.
//  - Drives the FIFO write port (wdata/winc) and honours its wfull flag.
//  - A beat with in_last closes a partial word, padding the unused lanes with PAD_VAL.
// PARAMETERS
//  IN_W     8      input beat width, bits
//  RATIO    4      beats per FIFO word; power of two, >=2
//  DSIZE    32     FIFO word width; must equal IN_W*RATIO (elaboration error otherwise)
//  PAD_VAL  0      IN_W-bit fill value for unused lanes of a partial word
// PORTS
//  wclk       in   1        write clock
//  wrst_n     in   1        asynchronous, active-low reset
//  in_data    in   IN_W     input beat
//  in_valid   in   1        beat present
//  in_last    in   1        beat closes the current word (qualified by in_valid)
//  in_ready   out  1        beat accepted when in_valid && in_ready
//  wfull      in   1        FIFO full flag (combinational from FIFO, wclk domain)
//  winc       out  1        FIFO write strobe
//  wdata      out  DSIZE    FIFO write data; lane 0 = bits [IN_W-1:0] = first beat
//  stall_cnt  out  16       only with AFIFO_WR_STATS_EN (see CONFIGURATION)
// BEHAVIOUR
//  - State: lane counter lane[log2(RATIO)-1:0], assembly register asm, output register wdata_q, out_vld.
//  - Reset values: in_ready=1, winc=0, wdata=0, out_vld=0, lane=0, asm=0, stall_cnt=0.
//  - drain = out_vld && !wfull.
//  - winc  = drain. Never assert winc while wfull=1; the FIFO write fires on the same edge.
//  - in_ready = !out_vld || drain. Combinational; does not depend on in_valid or in_last.
//  - On an accepted beat, in_data is written into asm lane [lane].
//  - Word close: an accepted beat with lane==RATIO-1, or with in_last=1.
//    - The closed word is asm with this cycle's beat merged and lanes above [lane] set to PAD_VAL.
//    - It loads wdata_q and sets out_vld; lane returns to 0 and asm clears to all-PAD_VAL.
//  - Otherwise an accepted beat increments lane.
//  - drain with no close on the same edge: out_vld clears.
//  - drain and close on the same edge: wdata_q reloads and out_vld stays 1, giving back-to-back writes.
//  - Latency: closing beat at edge N -> winc high in cycle N+1 if wfull=0; the word is written at edge N+1.
//  - Throughput: one FIFO word per RATIO input cycles, sustained while wfull=0.
//  - wfull high: out_vld holds, in_ready=0, no beats accepted, wdata_q stable.
//  - Partial progress in asm is retained across the stall.
//  - A beat with in_last=1 on lane RATIO-1 closes a single full word, not a word plus an empty pad word.
//  - in_last with in_valid=0 is ignored.
//  - Reset mid-operation: the partial word and any pending wdata_q are discarded; winc drops immediately (async).
// CONFIGURATION
//  - AFIFO_WR_STATS_EN defined: stall_cnt port present.
//    - It counts cycles with out_vld && wfull and saturates at 16'hFFFF.
//    - It clears only on wrst_n.
//  - AFIFO_WR_STATS_EN undefined: no stall_cnt port and no counter logic; all other behaviour is identical.
// STRUCTURE
//  - Shared package afifo_pkg holds:
//    - a clog2 function;
//    - the lane-index width localparam derived from RATIO;
//    - the stall-counter width constant (16).
//  - No sub-module: a single always block for state plus combinational handshake assigns.
//  - The AFIFO_WR_STATS_EN counter sits in its own `ifdef section.
// TESTING
//  1. Reset release, then beats 11,22,33,44 with wfull=0 -> winc 1 cycle after the 4th beat, wdata=32'h44332211.
//  2. Beats AA,BB with in_last on BB, PAD_VAL=0 -> wdata=32'h0000BBAA; the next word starts at lane 0.
//  3. Continuous beats 00..07, wfull=0 -> words 32'h03020100 and 32'h07060504; in_ready stays 1.
//  4. Word pending, wfull=1 for 5 cycles -> winc=0, in_ready=0, wdata stable.
//     - With AFIFO_WR_STATS_EN, stall_cnt=5.
//     - After wfull falls, one write of that word occurs.
//  5. wrst_n pulsed low after 2 of 4 beats -> no winc; the next 4 beats produce a word with no stale lanes.
//  6. in_last on the 4th lane -> exactly one winc, no extra padded word.

Source files
------------

// File: rtl/afifo_pkg.sv
// ---------------------------------------------------------------------------
// afifo_pkg
// Shared constants and helpers for the asynchronous FIFO blocks.
//   clog2          : ceiling log2 for sizing index fields
//   AFIFO_RATIO    : default beats per FIFO word
//   AFIFO_LANE_W   : lane-index width derived from the default ratio
//   STALL_CNT_W    : width of the optional write-stall statistics counter
// ---------------------------------------------------------------------------
package afifo_pkg;

  // Ceiling log2; returns 0 for an argument of 0 or 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  localparam int unsigned AFIFO_RATIO  = 4;
  localparam int unsigned AFIFO_LANE_W = clog2(AFIFO_RATIO);
  localparam int unsigned STALL_CNT_W  = 16;

endpackage

// File: rtl/afifo_wr_packer.sv
// ---------------------------------------------------------------------------
// afifo_wr_packer
// Write-side front end of the asynchronous FIFO (wclk domain). Packs RATIO
// narrow input beats into one DSIZE-bit word and pushes it into the FIFO
// write port, honouring wfull. A beat flagged in_last closes a partial word;
// the unused upper lanes are filled with PAD_VAL.
//
// Ports
//   wclk       in   write clock
//   wrst_n     in   asynchronous active-low reset
//   in_data    in   IN_W-bit input beat
//   in_valid   in   beat present
//   in_last    in   beat closes the current word (qualified by in_valid)
//   in_ready   out  beat accepted when in_valid && in_ready
//   wfull      in   FIFO full flag
//   winc       out  FIFO write strobe
//   wdata      out  FIFO write data, lane 0 (bits [IN_W-1:0]) = first beat
//   stall_cnt  out  saturating count of cycles stalled by wfull
//                   (present only when AFIFO_WR_STATS_EN is defined)
//
// Configuration macro: AFIFO_WR_STATS_EN enables the stall_cnt port/counter.
// ---------------------------------------------------------------------------
module afifo_wr_packer
  import afifo_pkg::*;
#(
  parameter int unsigned          IN_W    = 8,
  parameter int unsigned          RATIO   = 4,
  parameter int unsigned          DSIZE   = 32,
  parameter logic [IN_W-1:0]      PAD_VAL = '0
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata
`ifdef AFIFO_WR_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0]  stall_cnt
`endif
);

  localparam int unsigned LANE_W = clog2(RATIO);

  // Configuration sanity checks, evaluated at elaboration.
  if (DSIZE != IN_W * RATIO) begin : g_bad_dsize
    $error("afifo_wr_packer: DSIZE must equal IN_W*RATIO");
  end
  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("afifo_wr_packer: RATIO must be a power of two >= 2");
  end

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [DSIZE-1:0]  asm_q, asm_d;
  logic [DSIZE-1:0]  wdata_q, wdata_d;
  logic              out_vld_q, out_vld_d;

  logic              drain;
  logic              accept;
  logic              close;
  logic [DSIZE-1:0]  merged;

  // A pending word leaves on the same edge the FIFO sees winc, so the
  // output register can be refilled on that edge without a bubble.
  assign drain    = out_vld_q && !wfull;
  assign winc     = drain;
  assign in_ready = !out_vld_q || drain;
  assign wdata    = wdata_q;

  assign accept = in_valid && in_ready;
  assign close  = accept && (in_last || (lane_q == LANE_W'(RATIO - 1)));

  // Current assembly with this cycle's beat dropped into its lane and every
  // lane above it forced to PAD_VAL, so a closed partial word is padded even
  // if the assembly register still holds reset zeros.
  always_comb begin
    merged = asm_q;
    for (int i = 0; i < int'(RATIO); i++) begin
      if (i == int'(lane_q)) begin
        merged[i*IN_W +: IN_W] = in_data;
      end else if (i > int'(lane_q)) begin
        merged[i*IN_W +: IN_W] = PAD_VAL;
      end
    end
  end

  // Next-state: closing a word loads the output register and restarts the
  // assembly at lane 0; a drain without a new close empties the output.
  always_comb begin
    lane_d    = lane_q;
    asm_d     = asm_q;
    wdata_d   = wdata_q;
    out_vld_d = out_vld_q;

    if (drain) begin
      out_vld_d = 1'b0;
    end

    if (accept) begin
      if (close) begin
        wdata_d   = merged;
        out_vld_d = 1'b1;
        lane_d    = '0;
        asm_d     = {RATIO{PAD_VAL}};
      end else begin
        asm_d  = merged;
        lane_d = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      lane_q    <= '0;
      asm_q     <= '0;
      wdata_q   <= '0;
      out_vld_q <= 1'b0;
    end else begin
      lane_q    <= lane_d;
      asm_q     <= asm_d;
      wdata_q   <= wdata_d;
      out_vld_q <= out_vld_d;
    end
  end

`ifdef AFIFO_WR_STATS_EN
  // Stall statistics: cycles where a word is waiting on a full FIFO.
  // Saturates rather than wrapping; cleared only by reset.
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_cnt_q <= '0;
    end else if (out_vld_q && wfull && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
